// File: rtl/booth_r4_seq_mult.sv
// Sequential signed radix-4 Booth multiplier: one Booth digit per cycle,
// N/2 iterations, 2N-bit product registered into the DONE cycle.
module booth_r4_seq_mult #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int W    = 2 * N;
  localparam int ITER = N / 2;
  localparam int KW   = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  mcand_q, acc_q;
  logic [N-1:0]  mplier_q;
  logic          prev_q;
  logic [KW-1:0] k_q;

  logic          accept, last, neg;
  logic [2:0]    trip;
  logic [W-1:0]  mag, pp, addend, acc_sum;

  assign accept = start && (state_q == IDLE || state_q == DONE);
  assign last   = (state_q == CALC) && (k_q == KW'(ITER - 1));

  // mplier_q is shifted right by two each iteration, so the current digit
  // always sits in the low bits; prev_q carries bit 2k-1.
  always_comb begin
    trip = {mplier_q[1:0], prev_q};
    mag  = '0;
    neg  = 1'b0;
    case (trip)
      3'b001, 3'b010: mag = mcand_q;
      3'b011:         mag = mcand_q << 1;
      3'b100: begin   mag = mcand_q << 1; neg = 1'b1; end
      3'b101, 3'b110: begin mag = mcand_q; neg = 1'b1; end
      default:        mag = '0;
    endcase
    pp      = mag << {k_q, 1'b0};
    addend  = neg ? ~pp : pp;
    acc_sum = acc_q + addend + W'(neg);
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = CALC;
      CALC: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = start ? CALC : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prev_q   <= 1'b0;
      acc_q    <= '0;
      k_q      <= '0;
      product  <= '0;
    end else if (accept) begin
      mcand_q  <= {{N{a[N-1]}}, a};
      mplier_q <= b;
      prev_q   <= 1'b0;
      acc_q    <= '0;
      k_q      <= '0;
    end else if (state_q == CALC) begin
      acc_q    <= acc_sum;
      mplier_q <= mplier_q >> 2;
      prev_q   <= mplier_q[1];
      k_q      <= k_q + KW'(1);
      if (last) product <= acc_sum;
    end
  end

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Directed bench for booth_r4_seq_mult (N=8): vector table plus hand-written
// sequences for ignored start, back-to-back accept and mid-CALC reset.
module tb_booth_r4_seq_mult;

  logic        clk, rst_n, start;
  logic [7:0]  a, b;
  logic        busy, done;
  logic [15:0] product;

  int n_cmp = 0;
  int n_bad = 0;

  booth_r4_seq_mult #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Waits at negedges until done; returns the negedge index (1 = first after accept).
  task automatic wait_done(output int n, output bit busy_ok);
    n = 1;
    busy_ok = 1'b1;
    while (!done && n < 20) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    if (busy) busy_ok = 1'b0;
  endtask

  task automatic run_op(input string nm, input logic [7:0] ta, input logic [7:0] tb,
                        input logic [15:0] exp);
    int n;
    bit bok;
    @(negedge clk);
    start = 1'b1; a = ta; b = tb;
    @(negedge clk);
    start = 1'b0; a = 8'($urandom); b = 8'($urandom);
    wait_done(n, bok);
    chk({nm, " latency"}, 32'(n), 32'd5);
    chk({nm, " busy"}, 32'(bok), 32'd1);
    chk({nm, " product"}, 32'(product), 32'(exp));
    @(negedge clk);
    chk({nm, " hold"}, 32'(product), 32'(exp));
    chk({nm, " done pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  bok;
    bit  extra;

    vecs[0]  = '{8'd3,    8'd5,    16'h000F};
    vecs[1]  = '{8'h80,   8'h80,   16'h4000};
    vecs[2]  = '{8'd127,  8'h80,   16'hC080};
    vecs[3]  = '{8'hFF,   8'd1,    16'hFFFF};
    vecs[4]  = '{8'h55,   8'd0,    16'h0000};
    vecs[5]  = '{8'd7,    8'd9,    16'h003F};
    vecs[6]  = '{8'd10,   8'hFD,   16'hFFE2};
    vecs[7]  = '{8'hFA,   8'hFA,   16'h0024};
    vecs[8]  = '{8'h80,   8'd127,  16'hC080};
    vecs[9]  = '{8'd127,  8'd127,  16'h3F01};
    vecs[10] = '{8'hFF,   8'hFF,   16'h0001};
    vecs[11] = '{8'h80,   8'd1,    16'hFF80};
    vecs[12] = '{8'd2,    8'hFE,   16'hFFFC};
    vecs[13] = '{8'h55,   8'hAA,   16'hE372};
    vecs[14] = '{8'd0,    8'h80,   16'h0000};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset product", 32'(product), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p);

    // start during CALC must be ignored
    @(negedge clk);
    start = 1'b1; a = 8'd7; b = 8'd9;
    @(negedge clk);                       // CALC cycle 1
    start = 1'b0;
    chk("ign busy1", 32'(busy), 32'd1);
    @(negedge clk);                       // CALC cycle 2
    start = 1'b1; a = 8'd2; b = 8'd2;
    @(negedge clk);
    start = 1'b0;
    n = 3;
    while (!done && n < 20) begin @(negedge clk); n++; end
    chk("ign latency", 32'(n), 32'd5);
    chk("ign product", 32'(product), 32'd63);
    extra = 1'b0;
    repeat (10) begin @(negedge clk); if (done) extra = 1'b1; end
    chk("ign no second done", 32'(extra), 32'd0);
    chk("ign product hold", 32'(product), 32'd63);

    // back-to-back with start held high
    @(negedge clk);
    start = 1'b1; a = 8'd10; b = 8'hFD;
    @(negedge clk);
    wait_done(n, bok);
    chk("b2b first latency", 32'(n), 32'd5);
    chk("b2b first product", 32'(product), 32'hFFE2);
    a = 8'hFA; b = 8'hFA;                 // presented on the DONE cycle
    @(negedge clk);
    chk("b2b reaccept busy", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(n, bok);
    chk("b2b spacing", 32'(n), 32'd5);
    chk("b2b busy", 32'(bok), 32'd1);
    chk("b2b second product", 32'(product), 32'h0024);
    @(negedge clk);
    chk("b2b idle after", 32'(done), 32'd0);

    // asynchronous reset mid-CALC
    @(negedge clk);
    start = 1'b1; a = 8'd100; b = 8'd100;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);                       // CALC cycle 2
    #2 rst_n = 1'b0;
    #1;
    chk("areset busy", 32'(busy), 32'd0);
    chk("areset done", 32'(done), 32'd0);
    chk("areset product", 32'(product), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    extra = 1'b0;
    repeat (8) begin @(negedge clk); if (done || busy) extra = 1'b1; end
    chk("areset no done", 32'(extra), 32'd0);
    run_op("post reset", 8'd4, 8'd4, 16'h0010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
